// File: rtl/matrix_writeback_if.sv
//------------------------------------------------------------------------------
// matrix_writeback_if : AXI4 write-only memory port (AW / W / B channels)
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface matrix_writeback_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
);
  logic                    m_awvalid;
  logic                    m_awready;
  logic [ADDR_WIDTH-1:0]   m_awaddr;
  logic [7:0]              m_awlen;
  logic [2:0]              m_awsize;
  logic [1:0]              m_awburst;
  logic                    m_awid;

  logic                    m_wvalid;
  logic                    m_wready;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wstrb;
  logic                    m_wlast;

  logic                    m_bvalid;
  logic                    m_bready;
  logic [1:0]              m_bresp;

  modport master (
    output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awid,
    input  m_awready,
    output m_wvalid, m_wdata, m_wstrb, m_wlast,
    input  m_wready,
    input  m_bvalid, m_bresp,
    output m_bready
  );

  modport slave (
    input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awid,
    output m_awready,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast,
    output m_wready,
    output m_bvalid, m_bresp,
    input  m_bready
  );
endinterface

`default_nettype wire

// File: rtl/matrix_writeback.sv
//------------------------------------------------------------------------------
// matrix_writeback : strided, work-group-wrapped AXI4 write master with counters
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module matrix_writeback #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start,
  input  wire logic [7:0][31:0]  control_reg,
  output logic      [15:0][31:0] status_reg,
  matrix_writeback_if.master     m
);

  localparam int c_beat_bytes = DATA_WIDTH / 8;
  localparam int c_size       = $clog2(c_beat_bytes);
  localparam int c_lanes      = DATA_WIDTH / 32;
  localparam int c_pend_w     = $clog2(MAX_OUTSTANDING + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_AW_ISSUE  = 3'd1,
    S_ROW_NEXT  = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_started;
  logic                  r_bready;

  logic [ADDR_WIDTH-1:0] r_init_addr;
  logic [31:0]           r_row_ops;
  logic [31:0]           r_all_ops;
  logic [31:0]           r_burst;
  logic [31:0]           r_stride;
  logic [31:0]           r_mask;
  logic                  r_flag;
  logic [7:0]            r_awlen;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_offset;
  logic [31:0]           r_row_cnt;

  logic [31:0]           r_aw_issued;
  logic [31:0]           r_w_beats;
  logic [31:0]           r_b_recvd;
  logic [31:0]           r_b_err;
  logic [31:0]           r_cycles;
  logic [31:0]           r_last_cycles;
  logic                  r_done;

  logic [c_pend_w-1:0]   r_pending;
  logic [7:0]            r_beat;
  logic [15:0]           r_w_burst;

  logic                  w_capture;
  logic                  w_start_run;
  logic [7:0]            w_awlen_calc;
  logic [31:0]           w_outstanding;
  logic                  w_awvalid;
  logic                  w_aw_hs;
  logic                  w_wvalid;
  logic                  w_wlast;
  logic                  w_w_hs;
  logic                  w_wlast_hs;
  logic                  w_b_hs;
  logic [31:0]           w_aw_count_nxt;
  logic [31:0]           w_row_nxt;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_unused;

  assign w_capture    = (r_state == S_IDLE) && r_started;
  assign w_start_run  = w_capture && (control_reg[3] != 32'd0);
  assign w_awlen_calc = 8'((control_reg[4] >> c_size) - 32'd1);

  // Issue is throttled by bursts accepted on AW but not yet answered on B.
  assign w_outstanding  = r_aw_issued - r_b_recvd;
  assign w_awvalid      = (r_state == S_AW_ISSUE) && (w_outstanding < 32'(MAX_OUTSTANDING));
  assign w_aw_hs        = w_awvalid && m.m_awready;
  assign w_aw_count_nxt = r_aw_issued + 32'd1;
  assign w_row_nxt      = r_row_cnt + 32'd1;

  assign w_wvalid   = (r_pending != '0);
  assign w_wlast    = (r_beat == r_awlen);
  assign w_w_hs     = w_wvalid && m.m_wready;
  assign w_wlast_hs = w_w_hs && w_wlast;
  assign w_b_hs     = m.m_bvalid && r_bready;

  assign w_unused = &{1'b0, control_reg[2], control_reg[7][31:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_started <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= start;
      r_bready  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_started) begin
          w_state_nxt = (control_reg[3] == 32'd0) ? S_DONE : S_AW_ISSUE;
        end
      end
      S_AW_ISSUE: begin
        if (w_aw_hs) begin
          if (w_aw_count_nxt == r_all_ops) begin
            w_state_nxt = S_WAIT_RESP;
          end else if (w_row_nxt == r_row_ops) begin
            w_state_nxt = S_ROW_NEXT;
          end
        end
      end
      S_ROW_NEXT:  w_state_nxt = S_AW_ISSUE;
      S_WAIT_RESP: begin
        if ((r_b_recvd == r_all_ops) && !w_wvalid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Shadow configuration and strided address generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_addr <= '0;
      r_row_ops   <= '0;
      r_all_ops   <= '0;
      r_burst     <= '0;
      r_stride    <= '0;
      r_mask      <= '0;
      r_flag      <= 1'b0;
      r_awlen     <= '0;
      r_base      <= '0;
      r_offset    <= '0;
      r_row_cnt   <= '0;
    end else if (w_capture) begin
      r_init_addr <= ADDR_WIDTH'(control_reg[0]);
      r_row_ops   <= control_reg[1];
      r_all_ops   <= control_reg[3];
      r_burst     <= control_reg[4];
      r_stride    <= control_reg[5] << 2;
      r_mask      <= control_reg[6] - 32'd1;
      r_flag      <= control_reg[7][0];
      r_awlen     <= w_awlen_calc;
      r_base      <= ADDR_WIDTH'(control_reg[0]);
      r_offset    <= '0;
      r_row_cnt   <= '0;
    end else if (r_state == S_ROW_NEXT) begin
      r_base    <= r_flag ? (r_base + ADDR_WIDTH'(r_burst)) : r_init_addr;
      r_offset  <= '0;
      r_row_cnt <= '0;
    end else if (w_aw_hs) begin
      r_offset  <= r_offset + ADDR_WIDTH'(r_stride);
      r_row_cnt <= w_row_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_issued <= '0;
      r_w_beats   <= '0;
      r_b_recvd   <= '0;
      r_b_err     <= '0;
      r_w_burst   <= '0;
    end else if (w_start_run) begin
      r_aw_issued <= '0;
      r_w_beats   <= '0;
      r_b_recvd   <= '0;
      r_b_err     <= '0;
      r_w_burst   <= '0;
    end else begin
      if (w_aw_hs)    r_aw_issued <= w_aw_count_nxt;
      if (w_w_hs)     r_w_beats   <= r_w_beats + 32'd1;
      if (w_wlast_hs) r_w_burst   <= r_w_burst + 16'd1;
      if (w_b_hs) begin
        r_b_recvd <= r_b_recvd + 32'd1;
        if (m.m_bresp != 2'b00) r_b_err <= r_b_err + 32'd1;
      end
    end
  end

  // W engine: one pending entry per accepted AW, retired by its wlast beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_beat    <= '0;
    end else begin
      case ({w_aw_hs, w_wlast_hs})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
      if (w_w_hs) r_beat <= w_wlast ? 8'd0 : (r_beat + 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles      <= '0;
      r_last_cycles <= '0;
      r_done        <= 1'b0;
    end else begin
      if (w_capture) begin
        r_cycles <= '0;
      end else if ((r_state == S_AW_ISSUE) || (r_state == S_ROW_NEXT) ||
                   (r_state == S_WAIT_RESP)) begin
        r_cycles <= r_cycles + 32'd1;
      end
      if (w_start_run) begin
        r_done <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_done        <= 1'b1;
        r_last_cycles <= r_cycles;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < c_lanes; gi++) begin : g_lane
      assign w_wdata[gi*32 +: 32] = {r_w_burst, r_beat, 8'(gi)};
    end
  endgenerate

  always_comb begin
    status_reg    = '0;
    status_reg[0] = {30'd0, r_done, (r_state != S_IDLE)};
    status_reg[1] = r_aw_issued;
    status_reg[2] = r_w_beats;
    status_reg[3] = r_b_recvd;
    status_reg[4] = r_b_err;
    status_reg[5] = r_last_cycles;
  end

  assign m.m_awvalid = w_awvalid;
  assign m.m_awaddr  = r_base + (r_offset & ADDR_WIDTH'(r_mask));
  assign m.m_awlen   = r_awlen;
  assign m.m_awsize  = 3'(c_size);
  assign m.m_awburst = 2'b01;
  assign m.m_awid    = 1'b0;
  assign m.m_wvalid  = w_wvalid;
  assign m.m_wdata   = w_wdata;
  assign m.m_wstrb   = '1;
  assign m.m_wlast   = w_wlast;
  assign m.m_bready  = r_bready;

endmodule

`default_nettype wire

// File: tb/tb_matrix_writeback.sv
//------------------------------------------------------------------------------
// tb_matrix_writeback : randomized AXI slave plus address/data reference model
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_matrix_writeback;
  localparam int DW = 512;
  localparam int AW = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0][31:0] control_reg;
  logic [15:0][31:0] status_reg;

  matrix_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  matrix_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .control_reg(control_reg), .status_reg(status_reg), .m(bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int ready_pct = 100;
  bit b_hold    = 1'b0;
  int err_idx   = -1;
  int b_sent    = 0;
  int b_owed    = 0;
  bit b_hs      = 1'b0;

  logic [63:0]  aw_q[$];
  logic [7:0]   awlen_q[$];
  logic [511:0] wd_q[$];
  bit           wl_q[$];

  logic [31:0] m_init, m_row, m_all, m_burst, m_dim, m_wgs;
  bit          m_flag;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Address the k-th burst should carry, straight from the row/stride/wrap rules.
  function automatic logic [63:0] addr_model(int k);
    int unsigned row = k / m_row;
    int unsigned col = k % m_row;
    logic [63:0] base = m_flag ? (64'(m_init) + 64'(row) * 64'(m_burst)) : 64'(m_init);
    logic [31:0] stride = m_dim * 32'd4;
    logic [63:0] off = 64'(col) * 64'(stride);
    return base + (off & 64'(m_wgs - 32'd1));
  endfunction

  function automatic logic [511:0] pat(int k, int b);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = {k[15:0], b[7:0], i[7:0]};
    return r;
  endfunction

  // Slave: random readiness, B only after the matching wlast, records handshakes.
  initial begin
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bvalid  = 1'b0;
    bus.m_bresp   = 2'b00;
    forever begin
      @(negedge clk);
      bus.m_awready = ($urandom_range(99) < ready_pct);
      bus.m_wready  = ($urandom_range(99) < ready_pct);
      if (!(bus.m_bvalid && !b_hs)) begin
        if (b_owed > 0 && !b_hold && ($urandom_range(99) < ready_pct)) begin
          bus.m_bvalid = 1'b1;
          bus.m_bresp  = (b_sent == err_idx) ? 2'b10 : 2'b00;
        end else begin
          bus.m_bvalid = 1'b0;
          bus.m_bresp  = 2'b00;
        end
      end
      #1;
      if (rst) begin
        b_owed = 0; b_sent = 0; b_hs = 1'b0;
        bus.m_bvalid = 1'b0; bus.m_awready = 1'b0; bus.m_wready = 1'b0;
      end else begin
        if (bus.m_awvalid && bus.m_awready) begin
          aw_q.push_back(bus.m_awaddr);
          awlen_q.push_back(bus.m_awlen);
        end
        if (bus.m_wvalid && bus.m_wready) begin
          wd_q.push_back(bus.m_wdata);
          wl_q.push_back(bus.m_wlast);
          if (bus.m_wlast) b_owed++;
        end
        b_hs = bus.m_bvalid && bus.m_bready;
        if (b_hs) begin b_owed--; b_sent++; end
      end
    end
  end

  task automatic start_run(input logic [31:0] init, row, all, burst, dim, wgs,
                           input bit flag, input int pct, input int eidx);
    @(negedge clk);
    aw_q.delete(); awlen_q.delete(); wd_q.delete(); wl_q.delete();
    b_sent = 0;
    m_init = init; m_row = row; m_all = all; m_burst = burst;
    m_dim = dim; m_wgs = wgs; m_flag = flag;
    ready_pct = pct; err_idx = eidx;
    control_reg = '0;
    control_reg[0] = init; control_reg[1] = row; control_reg[2] = all / row;
    control_reg[3] = all;  control_reg[4] = burst; control_reg[5] = dim;
    control_reg[6] = wgs;  control_reg[7] = {31'd0, flag};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!(status_reg[0][1] && !status_reg[0][0]) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_within_budget", cyc < 5000, 1);
  endtask

  task automatic check_run(input string tag);
    int bpb = m_burst / 64;
    int nerr = (err_idx >= 0 && err_idx < int'(m_all)) ? 1 : 0;
    #2;
    check({tag, "_aw_count"}, aw_q.size(), m_all);
    for (int k = 0; k < aw_q.size() && k < int'(m_all); k++) begin
      check($sformatf("%s_awaddr%0d", tag, k), aw_q[k], addr_model(k));
      check($sformatf("%s_awlen%0d", tag, k), awlen_q[k], 8'(bpb - 1));
    end
    check({tag, "_w_count"}, wd_q.size(), m_all * bpb);
    for (int n = 0; n < wd_q.size() && n < int'(m_all) * bpb; n++) begin
      check($sformatf("%s_wdata%0d", tag, n), wd_q[n], pat(n / bpb, n % bpb));
      check($sformatf("%s_wlast%0d", tag, n), wl_q[n], (n % bpb) == bpb - 1);
    end
    check({tag, "_st_done"}, status_reg[0], 32'd2);
    check({tag, "_st_aw"},   status_reg[1], m_all);
    check({tag, "_st_w"},    status_reg[2], m_all * bpb);
    check({tag, "_st_b"},    status_reg[3], m_all);
    check({tag, "_st_err"},  status_reg[4], nerr);
    check({tag, "_st_cyc"},  status_reg[5] != 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    control_reg = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_status", status_reg, '0);
    check("rst_awvalid", bus.m_awvalid, 1'b0);
    check("rst_wvalid", bus.m_wvalid, 1'b0);
    check("rst_bready", bus.m_bready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    #2;
    check("bready_after_rst", bus.m_bready, 1'b1);

    // Basic single-row run, full readiness.
    start_run(32'h1000, 4, 4, 128, 16, 32'h1000, 1'b0, 100, -1);
    wait_done();
    check_run("basic");

    // Stride equals the work-group size: every address wraps to init_addr.
    start_run(32'h1000, 4, 4, 128, 1024, 32'h1000, 1'b0, 100, -1);
    wait_done();
    check_run("wrap");

    // Row stepping with and without the base-advance flag.
    start_run(32'h0, 2, 6, 64, 0, 32'h1000, 1'b1, 100, -1);
    wait_done();
    check_run("flag1");
    start_run(32'h0, 2, 6, 64, 0, 32'h1000, 1'b0, 100, -1);
    wait_done();
    check_run("flag0");

    // Withheld B: issue must stop at the outstanding limit.
    b_hold = 1'b1;
    start_run(32'h4000, 32, 32, 128, 16, 32'h10000, 1'b0, 100, -1);
    repeat (200) @(negedge clk);
    #2;
    check("outst_aw_count", aw_q.size(), 16);
    check("outst_awvalid", bus.m_awvalid, 1'b0);
    check("outst_st_b", status_reg[3], 32'd0);
    b_hold = 1'b0;
    wait_done();
    check_run("outst");

    // Random configurations under random back-pressure; the first has one SLVERR.
    for (int r = 0; r < 3; r++) begin
      logic [31:0] all = $urandom_range(6, 24);
      start_run($urandom & 32'hFFFF_F000, $urandom_range(1, 5), all,
                32'd64 << $urandom_range(0, 2), $urandom_range(0, 300),
                32'd1 << $urandom_range(6, 16), 1'($urandom_range(0, 1)),
                $urandom_range(30, 80), (r == 0) ? int'($urandom_range(0, all - 1)) : -1);
      wait_done();
      check_run($sformatf("rand%0d", r));
    end

    // Reset in the middle of issue, then a clean rerun.
    start_run(32'h2000, 40, 40, 256, 8, 32'h400, 1'b1, 60, -1);
    repeat (3) @(negedge clk);
    check("midrst_busy", status_reg[0][0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("midrst_awvalid", bus.m_awvalid, 1'b0);
    check("midrst_wvalid", bus.m_wvalid, 1'b0);
    check("midrst_bready", bus.m_bready, 1'b0);
    check("midrst_status", status_reg, '0);
    @(negedge clk);
    rst = 1'b0;
    start_run(32'h3000, 3, 5, 128, 32, 32'h800, 1'b1, 70, -1);
    wait_done();
    check_run("rerun");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
